// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared widths, word type and overflow helper for the 16-bit
//            ripple-of-CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 4;

    typedef logic [15:0] word16_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla4_slice
// Purpose  : Combinational 4-bit carry-lookahead slice with group P/G outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c0,
    output logic [SLICE_W-1:0] s,
    output logic               c4,
    output logic               grp_p,
    output logic               grp_g
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum of products of c0, never chained off the previous carry.
    assign w_c[0] = c0;
    assign w_c[1] = w_g[0] | (w_p[0] & c0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c0);

    assign grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign grp_p = &w_p;
    assign c4    = grp_g | (grp_p & c0);

    assign s = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/cla16_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla16_ripple_adder
// Purpose  : 16-bit adder of four rippled CLA slices with a registered result.
//            Define CLA16_OVF_EN to add the registered signed-overflow port ovf.
// Revision : 1.0 - initial release
// ============================================================================
module cla16_ripple_adder
    import cla_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  word16_t a,
    input  word16_t b,
    input  logic    cin,
    output word16_t s,
    output logic    cout,
`ifdef CLA16_OVF_EN
    output logic    ovf,
`endif
    output logic    out_valid
);

    logic [NUM_SLICES:0]   w_carry;
    word16_t               w_sum;
    // Group P/G are kept available for a future full-lookahead variant.
    logic [NUM_SLICES-1:0] w_grp_p_unused;
    logic [NUM_SLICES-1:0] w_grp_g_unused;

    assign w_carry[0] = cin;

    generate
        for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
            cla4_slice u_slice (
                .a     (a[k*SLICE_W +: SLICE_W]),
                .b     (b[k*SLICE_W +: SLICE_W]),
                .c0    (w_carry[k]),
                .s     (w_sum[k*SLICE_W +: SLICE_W]),
                .c4    (w_carry[k+1]),
                .grp_p (w_grp_p_unused[k]),
                .grp_g (w_grp_g_unused[k])
            );
        end
    endgenerate

    word16_t s_q, s_d;
    logic    cout_q, cout_d;
    logic    valid_q;

    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        if (in_valid) begin
            s_d    = w_sum;
            cout_d = w_carry[NUM_SLICES];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= in_valid;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

`ifdef CLA16_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = signed_ovf(a[15], b[15], w_sum[15]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla16_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla16_ripple_adder
// Purpose  : Self-checking bench: arithmetic reference model plus directed
//            literal vectors for cla16_ripple_adder (honours CLA16_OVF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla16_ripple_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        cin = 1'b0;
    logic [15:0] s;
    logic        cout;
    logic        out_valid;
`ifdef CLA16_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    cla16_ripple_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
`ifdef CLA16_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on what was presented at each edge.
    logic [15:0] m_s     = 16'h0;
    logic        m_cout  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s = 16'h0; m_cout = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                int unsigned u;
                int          sgn;
                u      = int'(a) + int'(b) + int'(cin);
                m_s    = u[15:0];
                m_cout = u[16];
                sgn    = int'($signed(a)) + int'($signed(b)) + int'(cin);
                m_ovf  = (sgn > 32767) || (sgn < -32768);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic ok;
            ok = (s === m_s) && (cout === m_cout) && (out_valid === m_valid);
`ifdef CLA16_OVF_EN
            ok = ok && (ovf === m_ovf);
`endif
            n_checks++;
            if (!ok) begin
                n_errors++;
`ifdef CLA16_OVF_EN
                $display("FAIL model t=%0t: got s=%h cout=%b vld=%b ovf=%b, want s=%h cout=%b vld=%b ovf=%b",
                         $time, s, cout, out_valid, ovf, m_s, m_cout, m_valid, m_ovf);
`else
                $display("FAIL model t=%0t: got s=%h cout=%b vld=%b, want s=%h cout=%b vld=%b",
                         $time, s, cout, out_valid, m_s, m_cout, m_valid);
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Present one operation, then land just after the capturing edge.
    task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset held with live-looking inputs.
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_s", s, 16'h0000);
            chk("rst_cout", {15'b0, cout}, 16'h0);
            chk("rst_vld", {15'b0, out_valid}, 16'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        op(16'hFFFF, 16'hFFFF, 1'b0);
        chk("max_s", s, 16'hFFFE);
        chk("max_cout", {15'b0, cout}, 16'h1);
        chk("max_vld", {15'b0, out_valid}, 16'h1);

        op(16'hFFFF, 16'h0000, 1'b1);
        chk("ripple_s", s, 16'h0000);
        chk("ripple_cout", {15'b0, cout}, 16'h1);

        op(16'h000F, 16'h0001, 1'b0);
        chk("slice0_s", s, 16'h0010);
        chk("slice0_cout", {15'b0, cout}, 16'h0);

        op(16'h0FFF, 16'h0001, 1'b0);
        chk("slice2_s", s, 16'h1000);

        op(16'h1234, 16'h4321, 1'b0);
        chk("b2b1_s", s, 16'h5555);
        chk("b2b1_cout", {15'b0, cout}, 16'h0);
        op(16'h8000, 16'h8000, 1'b0);
        chk("b2b2_s", s, 16'h0000);
        chk("b2b2_cout", {15'b0, cout}, 16'h1);
        chk("b2b2_vld", {15'b0, out_valid}, 16'h1);
`ifdef CLA16_OVF_EN
        chk("b2b2_ovf", {15'b0, ovf}, 16'h1);
`endif

        // Idle cycles with changing operands must not disturb the held result.
        in_valid = 1'b0; a = 16'h7777; b = 16'h1111; cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("hold_s", s, 16'h0000);
            chk("hold_cout", {15'b0, cout}, 16'h1);
            chk("hold_vld", {15'b0, out_valid}, 16'h0);
        end

        for (int i = 0; i < 10000; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        // Asynchronous reset arriving while an operation is in flight.
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("async_s", s, 16'h0000);
        chk("async_vld", {15'b0, out_valid}, 16'h0);
        @(posedge clk); #1;
        chk("async_hold_vld", {15'b0, out_valid}, 16'h0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_vld", {15'b0, out_valid}, 16'h0);
        chk("post_rst_s", s, 16'h0000);

        op(16'h00FF, 16'h0F01, 1'b1);
        chk("post_rst_op_s", s, 16'h1001);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cla16_ripple_adder.md
Name: cla16_ripple_adder

Overview:
- 16-bit binary adder built from four 4-bit carry-lookahead (CLA) slices.
- The carry ripples between slices: slice k's carry-out is slice k+1's carry-in.
- The combinational sum and carry are captured in an output register, giving a fixed one-cycle latency with a valid flag.
- Used as the datapath adder in the lab ALU; it is the reference point for comparing ripple-of-CLA against full-lookahead adders.

Parameters:
- none. Width is fixed at 16 bits, as four 4-bit slices.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a/b/cin are valid this cycle
- a  input  16  operand A, unsigned
- b  input  16  operand B, unsigned
- cin  input  1  carry-in to bit 0
- s  output  16  registered sum
- cout  output  1  registered carry-out of bit 15
- out_valid  output  1  s/cout hold the result of the operands sampled on the previous edge
- ovf  output  1  registered signed overflow; present only with CLA16_OVF_EN

Behaviour:
- Per bit i: g_i = a_i & b_i, p_i = a_i ^ b_i.
- Within each 4-bit slice, carries are lookahead, not rippled:
  - c1 = g0 | p0&c0
  - c2 = g1 | p1&g0 | p1&p0&c0
  - c3 and c4 follow the same expanded form.
  - sum_i = p_i ^ c_i.
- Slice carries: c0 of slice 0 = cin; c0 of slice k+1 = c4 of slice k; cout = c4 of slice 3.
- Arithmetic: {cout, s} = a + b + cin, as a 17-bit unsigned result with no saturation. Wrap-around is expressed only through cout.
- Register stage, on each rising clk:
  - out_valid <= in_valid.
  - If in_valid = 1: s <= sum, cout <= carry.
  - If in_valid = 0: s and cout hold their previous values.
- Latency: exactly 1 cycle from sampled inputs to registered outputs. Throughput: 1 operation per cycle; back-to-back in_valid is fully supported with no stalls.
- Reset: rst = 1 asynchronously forces s = 0, cout = 0, out_valid = 0 (and ovf = 0). Outputs stay at these values while rst is high, regardless of in_valid.
- Deassertion of rst is synchronous to clk. The first capture happens on the first rising edge after deassertion.
- If reset is asserted mid-operation, any in-flight result is discarded and no out_valid is produced for it.
- Boundary cases:
  - 0xFFFF + 0x0000 + 1: full carry chain through all four slices gives s = 0x0000, cout = 1.
  - 0xFFFF + 0xFFFF + 0: s = 0xFFFE, cout = 1.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro: CLA16_OVF_EN.
- With the macro defined: port ovf exists.
  - ovf <= (a[15] == b[15]) && (sum[15] != a[15]).
  - It is captured under the same in_valid / reset rules as s and cout.
- Without the macro: port ovf and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package cla_pkg:
  - localparam SLICE_W = 4
  - localparam NUM_SLICES = 4
  - typedef logic [15:0] word16_t
- One natural sub-module, cla4_slice:
  - Purely combinational.
  - Inputs: a[3:0], b[3:0], c0.
  - Outputs: s[3:0], c4, plus slice group propagate P and group generate G for future lookahead reuse.
- The top instantiates four cla4_slice instances, chains their carries, and holds the output register.

Test Plan:
- Reset: rst = 1 with in_valid = 1, a = b = 0xFFFF, across clock edges. Required: s = 0, cout = 0, out_valid = 0 throughout. After release, one valid op produces its result on the next edge.
- Max operands: a = 0xFFFF, b = 0xFFFF, cin = 0, in_valid = 1. Required next cycle: s = 0xFFFE, cout = 1, out_valid = 1.
- Full carry ripple: a = 0xFFFF, b = 0x0000, cin = 1. Required: s = 0x0000, cout = 1.
- Slice-boundary carry: a = 0x000F, b = 0x0001, cin = 0. Required: s = 0x0010, cout = 0. Also a = 0x0FFF, b = 0x0001. Required: s = 0x1000.
- Hold and back-to-back:
  - Inputs 0x1234 + 0x4321 + 0, then 0x8000 + 0x8000 + 0 on consecutive cycles. Required: s = 0x5555 / cout = 0, then s = 0x0000 / cout = 1 (ovf = 1 when CLA16_OVF_EN is defined).
  - Then in_valid = 0. Required: s and cout hold, out_valid = 0.
- Random: 10k random a/b/cin compared against a 17-bit reference sum, with one-cycle alignment.
